// File: rtl/gradient_magnitude_seq.sv
// gradient_magnitude_seq: multi-cycle sqrt(gx^2+gy^2) with saturation; define GMAG_ROUND_EN for round-to-nearest
module gradient_magnitude_seq #(
  parameter int IN_W = 8,
  parameter int OUT_W = 8,
  parameter int SIGNED_IN = 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  gx,
  input  logic [IN_W-1:0]  gy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] gmag,
  output logic             sat
);
  localparam int ROOT_W = IN_W + 1;
  localparam int SW = 2 * ROOT_W;
  localparam int RW = ROOT_W + 4;
  localparam int QF = ROOT_W + 1;
  localparam int MW = (QF > OUT_W) ? QF : OUT_W;
  localparam int CW = $clog2(ROOT_W + 1);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] SQ   = 3'd1;
  localparam logic [2:0] ITER = 3'd2;
  localparam logic [2:0] FIN  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;
  logic [2:0]      state;
  logic [IN_W-1:0] gx_r, gy_r, ax, ay;
  logic [SW-1:0]   rad, s_val;
  logic [RW-1:0]   rem, rem_sh, trial, rem_nx;
  logic [ROOT_W-1:0] q, q_nx;
  logic [CW-1:0]   cnt;
  logic [QF-1:0]   q_fin;
  logic [MW-1:0]   qx;
  logic            sat_n;
  logic [OUT_W-1:0] gmag_n;
  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign out_valid = (state == DONE);
  // The most negative input negates to 2^(IN_W-1), which still fits unsigned in IN_W bits.
  assign ax = (SIGNED_IN != 0 && gx_r[IN_W-1]) ? ~gx_r + 1'b1 : gx_r;
  assign ay = (SIGNED_IN != 0 && gy_r[IN_W-1]) ? ~gy_r + 1'b1 : gy_r;
  assign s_val = SW'(ax) * SW'(ax) + SW'(ay) * SW'(ay);
  // Non-restoring step: remainder carries headroom bits so its sign bit is always meaningful.
  assign rem_sh = RW'({rem, rad[SW-1:SW-2]});
  assign trial = RW'({q, rem[RW-1], 1'b1});
  assign rem_nx = rem[RW-1] ? rem_sh + trial : rem_sh - trial;
  assign q_nx = {q[ROOT_W-2:0], ~rem_nx[RW-1]};
`ifdef GMAG_ROUND_EN
  logic [RW-1:0] rem_c;
  assign rem_c = rem[RW-1] ? rem + RW'({q, 1'b1}) : rem;
  assign q_fin = {1'b0, q} + QF'(rem_c > RW'(q));
`else
  assign q_fin = {1'b0, q};
`endif
  assign qx = MW'(q_fin);
  assign sat_n = qx > MW'({OUT_W{1'b1}});
  assign gmag_n = sat_n ? '1 : qx[OUT_W-1:0];
  // Handshake-driven FSM running the square, the root iterations and the output hold.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      gx_r <= '0;
      gy_r <= '0;
      rad <= '0;
      rem <= '0;
      q <= '0;
      cnt <= '0;
      gmag <= '0;
      sat <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        gx_r <= gx;
        gy_r <= gy;
      end
      case (state)
        IDLE: state <= in_valid ? SQ : IDLE;
        SQ: begin
          rad <= s_val;
          rem <= '0;
          q <= '0;
          cnt <= '0;
          state <= ITER;
        end
        ITER: begin
          rad <= {rad[SW-3:0], 2'b00};
          rem <= rem_nx;
          q <= q_nx;
          cnt <= cnt + 1'b1;
          state <= (cnt == CW'(ROOT_W - 1)) ? FIN : ITER;
        end
        FIN: begin
          gmag <= gmag_n;
          sat <= sat_n;
          state <= DONE;
        end
        DONE: state <= out_ready ? (in_valid ? SQ : IDLE) : DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gradient_magnitude_seq.sv
// tb_gradient_magnitude_seq: signed and unsigned instances checked against an integer sqrt model
module tb_gradient_magnitude_seq;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [7:0] gx = 8'd0;
  logic [7:0] gy = 8'd0;
  logic in_ready, out_valid, sat, u_in_ready, u_out_valid, u_sat;
  logic [7:0] gmag, u_gmag;
  int checks = 0;
  int failures = 0;

  gradient_magnitude_seq #(.IN_W(8), .OUT_W(8), .SIGNED_IN(1)) dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready), .gx(gx), .gy(gy),
    .out_valid(out_valid), .out_ready(out_ready), .gmag(gmag), .sat(sat));
  gradient_magnitude_seq #(.IN_W(8), .OUT_W(8), .SIGNED_IN(0)) dut_u (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(u_in_ready), .gx(gx), .gy(gy),
    .out_valid(u_out_valid), .out_ready(out_ready), .gmag(u_gmag), .sat(u_sat));

  always #5 clk = ~clk;

  function automatic int mag(input int x, input int y, input bit sgn);
    int ax, ay, s, r;
    ax = (sgn && x >= 128) ? 256 - x : x;
    ay = (sgn && y >= 128) ? 256 - y : y;
    s = ax * ax + ay * ay;
    r = 0;
    while ((r + 1) * (r + 1) <= s) r++;
`ifdef GMAG_ROUND_EN
    if ((2 * r + 1) * (2 * r + 1) <= 4 * s) r++;
`endif
    return r;
  endfunction

  task automatic run_txn(input logic [7:0] x, input logic [7:0] y, output int lat);
    gx = x;
    gy = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    gx = 8'($urandom);
    gy = 8'($urandom);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic drain();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (gmag !== 8'd0) begin failures++; $display("FAIL reset_gmag got=%0d exp=0", gmag); end
    checks++; if (sat !== 1'b0) begin failures++; $display("FAIL reset_sat got=%b exp=0", sat); end
    n_rst = 1'b1;
    drain();
  endtask

  task automatic test_basic();
    int lat;
    run_txn(8'd3, 8'd4, lat);
    checks++; if (lat !== 11) begin failures++; $display("FAIL basic_latency got=%0d exp=11", lat); end
    checks++; if (gmag !== 8'd5) begin failures++; $display("FAIL basic_gmag got=%0d exp=5", gmag); end
    checks++; if (sat !== 1'b0) begin failures++; $display("FAIL basic_sat got=%b exp=0", sat); end
    checks++; if (u_gmag !== 8'd5) begin failures++; $display("FAIL basic_u_gmag got=%0d exp=5", u_gmag); end
    drain();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_consumed got=%b exp=0", out_valid); end
  endtask

  task automatic test_rounding();
    int lat;
    logic [7:0] exp13;
`ifdef GMAG_ROUND_EN
    exp13 = 8'd4;
`else
    exp13 = 8'd3;
`endif
    run_txn(8'd2, 8'd3, lat);
    checks++; if (gmag !== exp13) begin failures++; $display("FAIL round_s13 got=%0d exp=%0d", gmag, exp13); end
    drain();
    run_txn(8'd1, 8'd1, lat);
    checks++; if (gmag !== 8'd1) begin failures++; $display("FAIL round_s2 got=%0d exp=1", gmag); end
    drain();
  endtask

  task automatic test_signed();
    int lat;
    run_txn(8'h80, 8'h80, lat);
    checks++; if (gmag !== 8'd181) begin failures++; $display("FAIL signed_min got=%0d exp=181", gmag); end
    checks++; if (sat !== 1'b0) begin failures++; $display("FAIL signed_min_sat got=%b exp=0", sat); end
    drain();
    run_txn(8'd127, 8'h80, lat);
    checks++; if (gmag !== 8'd180) begin failures++; $display("FAIL signed_mix got=%0d exp=180", gmag); end
    drain();
  endtask

  task automatic test_unsigned();
    int lat;
    run_txn(8'd255, 8'd255, lat);
    checks++; if (u_gmag !== 8'd255) begin failures++; $display("FAIL unsigned_max got=%0d exp=255", u_gmag); end
    checks++; if (u_sat !== 1'b1) begin failures++; $display("FAIL unsigned_max_sat got=%b exp=1", u_sat); end
    drain();
    run_txn(8'd0, 8'd0, lat);
    checks++; if (u_gmag !== 8'd0) begin failures++; $display("FAIL unsigned_zero got=%0d exp=0", u_gmag); end
    checks++; if (u_sat !== 1'b0) begin failures++; $display("FAIL unsigned_zero_sat got=%b exp=0", u_sat); end
    drain();
  endtask

  task automatic test_random();
    int lat, x, y, e, eu;
    logic [7:0] eg, eug;
    logic es, eus;
    for (int n = 0; n < 16; n++) begin
      x = $urandom_range(0, 255);
      y = $urandom_range(0, 255);
      e = mag(x, y, 1'b1);
      eu = mag(x, y, 1'b0);
      eg = (e > 255) ? 8'd255 : 8'(e);
      es = e > 255;
      eug = (eu > 255) ? 8'd255 : 8'(eu);
      eus = eu > 255;
      run_txn(8'(x), 8'(y), lat);
      checks++; if (lat !== 11) begin failures++; $display("FAIL rand_latency x=%0d y=%0d got=%0d exp=11", x, y, lat); end
      checks++; if (gmag !== eg || sat !== es) begin failures++; $display("FAIL rand_signed x=%0d y=%0d got=%0d/%b exp=%0d/%b", x, y, gmag, sat, eg, es); end
      checks++; if (u_gmag !== eug || u_sat !== eus) begin failures++; $display("FAIL rand_unsigned x=%0d y=%0d got=%0d/%b exp=%0d/%b", x, y, u_gmag, u_sat, eug, eus); end
      drain();
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    out_ready = 1'b0;
    run_txn(8'd3, 8'd4, lat);
    checks++; if (lat !== 11) begin failures++; $display("FAIL bp_latency got=%0d exp=11", lat); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b1 || gmag !== 8'd5 || in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold cyc=%0d got=%b/%0d/%b exp=1/5/0", i, out_valid, gmag, in_ready); end
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    gx = 8'd6;
    gy = 8'd8;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_handoff_ready got=%b exp=1", in_ready); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    gx = 8'd0;
    gy = 8'd0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drop got=%b exp=0", out_valid); end
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    checks++; if (lat !== 11) begin failures++; $display("FAIL bp_next_latency got=%0d exp=11", lat); end
    checks++; if (gmag !== 8'd10) begin failures++; $display("FAIL bp_next_gmag got=%0d exp=10", gmag); end
    drain();
  endtask

  task automatic test_reset_mid();
    int lat, stale;
    gx = 8'd100;
    gy = 8'd100;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_hs got=%b/%b exp=1/0", in_ready, out_valid); end
    checks++; if (gmag !== 8'd0 || sat !== 1'b0) begin failures++; $display("FAIL rstmid_out got=%0d/%b exp=0/0", gmag, sat); end
    repeat (2) @(posedge clk);
    #2;
    n_rst = 1'b1;
    stale = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) stale++;
    end
    checks++; if (stale !== 0) begin failures++; $display("FAIL rstmid_stale got=%0d exp=0", stale); end
    run_txn(8'd5, 8'd12, lat);
    checks++; if (lat !== 11 || gmag !== 8'd13) begin failures++; $display("FAIL rstmid_fresh got=%0d lat=%0d exp=13 lat=11", gmag, lat); end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_signed();
    test_unsigned();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
